mem_diag_interface: RTL and testbench
=====================================

# mem_diag_interface

Parametrised per-memory BIST collar: the successor to the existing per-memory interface, sitting between the shared algorithm/background generator and one memory instance. It gates and maps controller commands onto the memory pins, generates per-lane write enables, and compares read data against delayed expected data over a configurable read latency. It also keeps a sticky scan-shiftable miscompare register and logs failing addresses in a small FIFO for diagnosis. The clock is already selected upstream; this block has no clock mux.

## Interface
- MEM_ADR_X, 2: memory row-address width (≤ ADDR_X)
- MEM_ADR_Y, 2: memory column-address width (≤ ADDR_Y)
- MEM_DATA, 7: memory data width
- MEM_ADR_X_MAX, 2**MEM_ADR_X-1: highest valid row
- MEM_ADR_Y_MAX, 2**MEM_ADR_Y-1: highest valid column
- BWE_GRAIN, 1: data bits per write-enable lane; lanes alternate even/odd from lane 0
- RD_LAT, 1: cycles from read request edge to i_q sample edge, 1..4
- LOG_DEPTH, 4: fail-log entries, power of 2, ≥ 2
- CNT_W, 8: fail-counter width

Ports (reset rstn, asynchronous, active-low; clock clk):
- clk  in  1  test clock
- rstn  in  1  async active-low reset
- i_addr_x / i_addr_y  in  ADDR_X / ADDR_Y  controller address
- i_data  in  BG_DATA  data background
- i_cs, i_we, i_re, i_oe, i_odd_bwe, i_even_bwe, i_comp_en  in  1 each  decoded command
- i_mbist_run  in  1  test active
- i_shift_mode, si  in  1  scan-shift miscompare register; so  out  1
- i_log_pop  in  1  pop fail-log head; i_log_clr  in  1  sync clear of all diagnostic state
- o_log_valid  out  1; o_log_addr  out  MEM_ADR_X+MEM_ADR_Y  head address {x,y}; o_log_mask  out  MEM_DATA  head miscompare bits
- o_log_ovf  out  1  sticky log overflow; o_fail_cnt  out  CNT_W  saturating failing-read count; o_fail_flag  out  1  OR of sticky register
- o_addr  out  MEM_ADR_X+MEM_ADR_Y; o_data  out  MEM_DATA; o_cs, o_we, o_re, o_oe  out  1; o_bwe  out  MEM_DATA
- i_q  in  MEM_DATA  memory read data

## Operation
- test_en = i_mbist_run & (i_addr_x ≤ MEM_ADR_X_MAX) & (i_addr_y ≤ MEM_ADR_Y_MAX). Each compare is statically true when MAX equals the controller maximum.
- Memory pins are combinational: o_cs/o_we/o_re/o_oe = input & test_en; o_addr = {i_addr_x[MEM_ADR_X-1:0], i_addr_y[MEM_ADR_Y-1:0]}.
- o_data is i_data replicated from bit 0 upward; the top partial copy is truncated.
- o_bwe[i] = i_we & test_en & (lane i/BWE_GRAIN even ? i_even_bwe : i_odd_bwe).
- Compare pipeline, RD_LAT stages, each holding {comp_en & test_en, i_data, mapped address}. At the last stage: mism = (i_q ^ expanded expected) & {MEM_DATA{stage_en}}. Expected data uses the same replication as o_data.
- Sticky register: if i_shift_mode, shift left with si entering at bit 0, so = bit MEM_DATA-1, and no compare merge. Otherwise reg |= mism.
- Failing read (|mism, not shift mode):
  - push {addr, mism} to the log if not full (pop in the same cycle counts as not full);
  - if full, drop the entry and set o_log_ovf;
  - o_fail_cnt += 1, saturating at all-ones.
- o_log_valid = log not empty; i_log_pop when empty is ignored; head outputs are don't-care when invalid.
- i_log_clr empties the log and clears o_log_ovf, o_fail_cnt, the sticky register and the pipeline. It has priority over push/pop/compare in the same cycle.

## Timing
- Read command present in the cycle before edge E0 → i_q sampled and merged at edge E0+RD_LAT-1+1 = E_RD_LAT. o_fail_flag / log / count update visible after that edge. RD_LAT=1 gives the legacy one-cycle compare.
- Memory-side outputs have zero latency (combinational). Bench samples them with the #1 model delay.
- All registers reset to 0 via rstn: pipeline, sticky register (so=0, o_fail_flag=0), log pointers (o_log_valid=0), o_log_ovf=0, o_fail_cnt=0.
- Reset mid-read discards the in-flight pipeline, so no late compare occurs.
- Pipeline keeps advancing during shift mode; compares landing then are lost.

## Structure
- Package pmbist: existing BG_DATA, ADDR_X, ADDR_Y, ADDR_*_MAX, t_op_cmd.
- Package pmbist additions: typedef t_fail_entry (address + mask, parametrised by the instance's widths via localparams) and constant RD_LAT_MAX = 4.
- One sub-module: fail_log_fifo (sync FIFO, width/depth params, push/pop/clr, full/empty, overflow sticky).

## Test plan
- MEM_ADR_X=2 with controller address x=5 and WRITE → o_cs=o_we=0, o_bwe=0, no compare pipeline entry.
- BWE_GRAIN=2, MEM_DATA=8, i_even_bwe=1, i_odd_bwe=0, write → o_bwe=8'b00110011.
- RD_LAT=3: READ at edge E0, i_q=7'h55 vs expected 7'h54 at E3 → o_fail_flag rises after E3 (not earlier); log head addr correct, mask 7'h01, o_fail_cnt=1.
- LOG_DEPTH=4: 5 failing reads, no pop → 4 entries kept, o_log_ovf=1; then a pop and a fail in the same cycle → entry accepted, count stays 4.
- Shift mode after fail 7'h01: 7 shifts with si=0 → so sequence 0,0,0,0,0,0,1, register 0.
- i_log_clr concurrent with a failing compare → everything 0 next cycle; rstn asserted mid-RD_LAT=3 read → no fail after release.

Source files
------------

// File: rtl/mem_diag_interface_pkg.sv
// Shared MBIST controller definitions plus the fail-log entry format used by
// every per-memory collar.
package pmbist;

    localparam int BG_DATA    = 8;
    localparam int ADDR_X     = 3;
    localparam int ADDR_Y     = 3;
    localparam int ADDR_X_MAX = 2**ADDR_X - 1;
    localparam int ADDR_Y_MAX = 2**ADDR_Y - 1;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_WRITE,
        OP_READ,
        OP_READ_WRITE,
        OP_WRITE_READ
    } t_op_cmd;

    localparam int RD_LAT_MAX = 4;

    // Sized for the widest collar; narrower instances zero-extend into it.
    localparam int FAIL_ADR_W  = ADDR_X + ADDR_Y;
    localparam int FAIL_MASK_W = 32;

    typedef struct packed {
        logic [FAIL_ADR_W-1:0]  addr;
        logic [FAIL_MASK_W-1:0] mask;
    } t_fail_entry;

endpackage

// File: rtl/mem_diag_interface_if.sv
// Memory-side pin bundle between the BIST collar (master) and the memory (slave).
interface mem_diag_interface_if #(
    parameter int ADR_W  = 4,
    parameter int DATA_W = 7
);
    logic [ADR_W-1:0]  o_addr;
    logic [DATA_W-1:0] o_data;
    logic              o_cs;
    logic              o_we;
    logic              o_re;
    logic              o_oe;
    logic [DATA_W-1:0] o_bwe;
    logic [DATA_W-1:0] i_q;

    modport master (
        output o_addr, o_data, o_cs, o_we, o_re, o_oe, o_bwe,
        input  i_q
    );

    modport slave (
        input  o_addr, o_data, o_cs, o_we, o_re, o_oe, o_bwe,
        output i_q
    );
endinterface

// File: rtl/mem_diag_interface_fail_log_fifo.sv
// Small synchronous FIFO holding failing-read records; drops pushes when full
// and remembers that it did so in a sticky overflow flag.
module fail_log_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_pop, do_push;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot the push is about to use.
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_q[AW-1:0]];
    assign ovf_o   = ovf_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            wr_d  = '0;
            rd_d  = '0;
            ovf_d = 1'b0;
        end else begin
            if (do_push)           wr_d  = wr_q + 1'b1;
            if (do_pop)            rd_d  = rd_q + 1'b1;
            if (push_i && !do_push) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/mem_diag_interface.sv
// Per-memory BIST collar: maps controller commands onto memory pins, compares
// read data after RD_LAT cycles, and keeps sticky/scan and fail-log diagnostics.
module mem_diag_interface
    import pmbist::*;
#(
    parameter int MEM_ADR_X     = 2,
    parameter int MEM_ADR_Y     = 2,
    parameter int MEM_DATA      = 7,
    parameter int MEM_ADR_X_MAX = 2**MEM_ADR_X - 1,
    parameter int MEM_ADR_Y_MAX = 2**MEM_ADR_Y - 1,
    parameter int BWE_GRAIN     = 1,
    parameter int RD_LAT        = 1,
    parameter int LOG_DEPTH     = 4,
    parameter int CNT_W         = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [ADDR_X-1:0]            i_addr_x,
    input  logic [ADDR_Y-1:0]            i_addr_y,
    input  logic [BG_DATA-1:0]           i_data,
    input  logic                         i_cs,
    input  logic                         i_we,
    input  logic                         i_re,
    input  logic                         i_oe,
    input  logic                         i_odd_bwe,
    input  logic                         i_even_bwe,
    input  logic                         i_comp_en,
    input  logic                         i_mbist_run,
    input  logic                         i_shift_mode,
    input  logic                         si,
    output logic                         so,
    input  logic                         i_log_pop,
    input  logic                         i_log_clr,
    output logic                         o_log_valid,
    output logic [MEM_ADR_X+MEM_ADR_Y-1:0] o_log_addr,
    output logic [MEM_DATA-1:0]          o_log_mask,
    output logic                         o_log_ovf,
    output logic [CNT_W-1:0]             o_fail_cnt,
    output logic                         o_fail_flag,
    mem_diag_interface_if.master         mem_if
);
    localparam int MEM_ADR_W = MEM_ADR_X + MEM_ADR_Y;

    // Background replicated from bit 0 upward, top copy truncated.
    function automatic logic [MEM_DATA-1:0] expand_bg(input logic [BG_DATA-1:0] d);
        logic [MEM_DATA-1:0] r;
        for (int i = 0; i < MEM_DATA; i++) r[i] = d[i % BG_DATA];
        return r;
    endfunction

    function automatic logic [MEM_DATA-1:0] lane_bwe(input logic we, input logic ev,
                                                      input logic od);
        logic [MEM_DATA-1:0] r;
        for (int i = 0; i < MEM_DATA; i++)
            r[i] = we & ((((i / BWE_GRAIN) % 2) == 0) ? ev : od);
        return r;
    endfunction

    logic                 test_en;
    logic [MEM_ADR_W-1:0] mem_addr;

    assign test_en  = i_mbist_run
                    & (i_addr_x <= ADDR_X'(MEM_ADR_X_MAX))
                    & (i_addr_y <= ADDR_Y'(MEM_ADR_Y_MAX));
    assign mem_addr = {i_addr_x[MEM_ADR_X-1:0], i_addr_y[MEM_ADR_Y-1:0]};

    assign mem_if.o_addr = mem_addr;
    assign mem_if.o_data = expand_bg(i_data);
    assign mem_if.o_cs   = i_cs & test_en;
    assign mem_if.o_we   = i_we & test_en;
    assign mem_if.o_re   = i_re & test_en;
    assign mem_if.o_oe   = i_oe & test_en;
    assign mem_if.o_bwe  = lane_bwe(i_we & test_en, i_even_bwe, i_odd_bwe);

    logic                 pen_q   [RD_LAT];
    logic [BG_DATA-1:0]   pdata_q [RD_LAT];
    logic [MEM_ADR_W-1:0] paddr_q [RD_LAT];

    // Expected-data pipeline; the last stage lines up with the i_q sample edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < RD_LAT; s++) begin
                pen_q[s]   <= 1'b0;
                pdata_q[s] <= '0;
                paddr_q[s] <= '0;
            end
        end else if (i_log_clr) begin
            for (int s = 0; s < RD_LAT; s++) begin
                pen_q[s]   <= 1'b0;
                pdata_q[s] <= '0;
                paddr_q[s] <= '0;
            end
        end else begin
            pen_q[0]   <= i_comp_en & test_en;
            pdata_q[0] <= i_data;
            paddr_q[0] <= mem_addr;
            for (int s = 1; s < RD_LAT; s++) begin
                pen_q[s]   <= pen_q[s-1];
                pdata_q[s] <= pdata_q[s-1];
                paddr_q[s] <= paddr_q[s-1];
            end
        end
    end

    logic [MEM_DATA-1:0] mism;
    logic                fail;
    logic [MEM_DATA-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    assign mism = (mem_if.i_q ^ expand_bg(pdata_q[RD_LAT-1])) & {MEM_DATA{pen_q[RD_LAT-1]}};
    assign fail = (|mism) & ~i_shift_mode;

    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (i_log_clr) begin
            sticky_d = '0;
            cnt_d    = '0;
        end else begin
            if (i_shift_mode) sticky_d = MEM_DATA'({sticky_q, si});
            else              sticky_d = sticky_q | mism;
            if (fail && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign so          = sticky_q[MEM_DATA-1];
    assign o_fail_flag = |sticky_q;
    assign o_fail_cnt  = cnt_q;

    t_fail_entry push_e, head_e;
    logic        log_full, log_empty;

    always_comb begin
        push_e      = '0;
        push_e.addr = FAIL_ADR_W'(paddr_q[RD_LAT-1]);
        push_e.mask = FAIL_MASK_W'(mism);
    end

    fail_log_fifo #(
        .WIDTH ($bits(t_fail_entry)),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (fail),
        .pop_i   (i_log_pop),
        .clr_i   (i_log_clr),
        .wdata_i (push_e),
        .rdata_o (head_e),
        .full_o  (log_full),
        .empty_o (log_empty),
        .ovf_o   (o_log_ovf)
    );

    assign o_log_valid = ~log_empty;
    assign o_log_addr  = MEM_ADR_W'(head_e.addr);
    assign o_log_mask  = MEM_DATA'(head_e.mask);

endmodule

// File: tb/tb_mem_diag_interface.sv
// Directed bench for the BIST collar: a RD_LAT=3 seven-bit instance and an
// eight-bit BWE_GRAIN=2 instance driven by the same controller stimulus.
module tb_mem_diag_interface;
    import pmbist::*;

    logic clk, rstn;
    logic [ADDR_X-1:0]  addr_x;
    logic [ADDR_Y-1:0]  addr_y;
    logic [BG_DATA-1:0] data;
    logic cs, we, re, oe, odd_bwe, even_bwe, comp_en, run, shift, si, pop, clr;

    logic       so_a, lv_a, ovf_a, ff_a;
    logic [3:0] laddr_a;
    logic [6:0] lmask_a;
    logic [7:0] cnt_a;
    logic       so_b, lv_b, ovf_b, ff_b;
    logic [3:0] laddr_b;
    logic [7:0] lmask_b;
    logic [7:0] cnt_b;

    int n_chk, n_bad;

    mem_diag_interface_if #(.ADR_W(4), .DATA_W(7)) mif_a ();
    mem_diag_interface_if #(.ADR_W(4), .DATA_W(8)) mif_b ();

    mem_diag_interface #(
        .MEM_ADR_X(2), .MEM_ADR_Y(2), .MEM_DATA(7), .BWE_GRAIN(1),
        .RD_LAT(3), .LOG_DEPTH(4), .CNT_W(8)
    ) u_dut_a (
        .clk(clk), .rstn(rstn), .i_addr_x(addr_x), .i_addr_y(addr_y), .i_data(data),
        .i_cs(cs), .i_we(we), .i_re(re), .i_oe(oe), .i_odd_bwe(odd_bwe),
        .i_even_bwe(even_bwe), .i_comp_en(comp_en), .i_mbist_run(run),
        .i_shift_mode(shift), .si(si), .so(so_a), .i_log_pop(pop), .i_log_clr(clr),
        .o_log_valid(lv_a), .o_log_addr(laddr_a), .o_log_mask(lmask_a),
        .o_log_ovf(ovf_a), .o_fail_cnt(cnt_a), .o_fail_flag(ff_a), .mem_if(mif_a)
    );

    mem_diag_interface #(
        .MEM_ADR_X(2), .MEM_ADR_Y(2), .MEM_DATA(8), .BWE_GRAIN(2),
        .RD_LAT(1), .LOG_DEPTH(4), .CNT_W(8)
    ) u_dut_b (
        .clk(clk), .rstn(rstn), .i_addr_x(addr_x), .i_addr_y(addr_y), .i_data(data),
        .i_cs(cs), .i_we(we), .i_re(re), .i_oe(oe), .i_odd_bwe(odd_bwe),
        .i_even_bwe(even_bwe), .i_comp_en(comp_en), .i_mbist_run(run),
        .i_shift_mode(shift), .si(si), .so(so_b), .i_log_pop(pop), .i_log_clr(clr),
        .o_log_valid(lv_b), .o_log_addr(laddr_b), .o_log_mask(lmask_b),
        .o_log_ovf(ovf_b), .o_fail_cnt(cnt_b), .o_fail_flag(ff_b), .mem_if(mif_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs = 0; we = 0; re = 0; oe = 0; odd_bwe = 0; even_bwe = 0;
        comp_en = 0; pop = 0; clr = 0; shift = 0;
    endtask

    task automatic rd(input logic [ADDR_X-1:0] x, input logic [ADDR_Y-1:0] y,
                      input logic [BG_DATA-1:0] d);
        cs = 1; re = 1; we = 0; oe = 1; comp_en = 1;
        addr_x = x; addr_y = y; data = d;
    endtask

    logic [3:0] exp_addr [4];
    int         n_pop;

    initial begin
        n_chk = 0; n_bad = 0;
        rstn = 0; run = 0; si = 0; idle();
        addr_x = '0; addr_y = '0; data = '0;
        mif_a.i_q = '0; mif_b.i_q = '0;
        exp_addr = '{4'h1, 4'h2, 4'h3, 4'hA};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_flag", ff_a, 0);
        chk("rst_so", so_a, 0);
        chk("rst_valid", lv_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_cnt", cnt_a, 0);
        rstn = 1;
        tick();
        run = 1;

        // Out-of-range row: pins gated, nothing enters the compare pipe.
        addr_x = 3'd5; addr_y = 3'd1; data = 8'hAA;
        cs = 1; we = 1; even_bwe = 1; odd_bwe = 1; comp_en = 1;
        mif_a.i_q = 7'h7F;
        #1;
        chk("oor_cs", mif_a.o_cs, 0);
        chk("oor_we", mif_a.o_we, 0);
        chk("oor_bwe", mif_a.o_bwe, 0);
        repeat (4) tick();
        chk("oor_flag", ff_a, 0);
        chk("oor_cnt", cnt_a, 0);
        addr_x = 3'd1; run = 0;
        #1;
        chk("norun_cs", mif_a.o_cs, 0);
        run = 1;
        idle();

        // In-range write: address map, data truncation, lane enables.
        addr_x = 3'd2; addr_y = 3'd3; data = 8'hA5;
        cs = 1; we = 1; oe = 1; even_bwe = 1; odd_bwe = 0;
        #1;
        chk("wr_cs", mif_a.o_cs, 1);
        chk("wr_we", mif_a.o_we, 1);
        chk("wr_oe", mif_a.o_oe, 1);
        chk("wr_re", mif_a.o_re, 0);
        chk("wr_addr", mif_a.o_addr, 4'hB);
        chk("wr_data_a", mif_a.o_data, 7'h25);
        chk("wr_data_b", mif_b.o_data, 8'hA5);
        chk("bwe_even_a", mif_a.o_bwe, 7'h55);
        chk("bwe_even_b", mif_b.o_bwe, 8'h33);
        even_bwe = 0; odd_bwe = 1;
        #1;
        chk("bwe_odd_a", mif_a.o_bwe, 7'h2A);
        chk("bwe_odd_b", mif_b.o_bwe, 8'hCC);
        tick();
        idle();

        // RD_LAT=3 read with a single-bit miscompare.
        mif_a.i_q = 7'h55;
        rd(3'd1, 3'd2, 8'h54);
        #1;
        chk("rd_re", mif_a.o_re, 1);
        chk("rd_bwe", mif_a.o_bwe, 0);
        tick();
        idle();
        chk("lat_e0", ff_a, 0);
        tick();
        chk("lat_e1", ff_a, 0);
        tick();
        chk("lat_e2", ff_a, 0);
        tick();
        chk("lat_e3_flag", ff_a, 1);
        chk("lat_e3_valid", lv_a, 1);
        chk("lat_e3_addr", laddr_a, 4'h6);
        chk("lat_e3_mask", lmask_a, 7'h01);
        chk("lat_e3_cnt", cnt_a, 1);

        // Scan the sticky register out.
        shift = 1; si = 0;
        for (int k = 0; k < 7; k++) begin
            chk("shift_so", so_a, (k == 6) ? 1 : 0);
            tick();
        end
        chk("shift_empty", ff_a, 0);
        si = 1;
        tick();
        chk("shift_si", ff_a, 1);
        shift = 0; si = 0;
        chk("shift_log_kept", cnt_a, 1);

        pop = 1;
        tick();
        pop = 0;
        chk("pop_empty", lv_a, 0);

        // Five back-to-back failing reads into a four-entry log.
        rd(3'd0, 3'd0, 8'h54); tick();
        rd(3'd0, 3'd1, 8'h54); tick();
        rd(3'd0, 3'd2, 8'h54); tick();
        rd(3'd0, 3'd3, 8'h54); tick();
        rd(3'd1, 3'd0, 8'h54); tick();
        idle();
        repeat (3) tick();
        chk("ovf_flag", ovf_a, 1);
        chk("ovf_cnt", cnt_a, 6);
        chk("ovf_head", laddr_a, 4'h0);

        // Pop and failing compare on the same edge while full.
        rd(3'd2, 3'd2, 8'h54);
        tick();
        idle();
        tick();
        tick();
        pop = 1;
        tick();
        pop = 0;
        chk("popfail_ovf", ovf_a, 1);
        chk("popfail_cnt", cnt_a, 7);
        n_pop = 0;
        for (int k = 0; k < 8 && lv_a; k++) begin
            if (k < 4) chk("drain_addr", laddr_a, exp_addr[k]);
            pop = 1;
            tick();
            pop = 0;
            n_pop++;
        end
        chk("drain_n", n_pop, 4);

        // Counter saturation.
        rd(3'd3, 3'd3, 8'h54);
        repeat (260) tick();
        idle();
        repeat (4) tick();
        chk("sat_cnt", cnt_a, 8'hFF);

        // Clear on the edge of a failing compare, with a second read in flight.
        rd(3'd0, 3'd0, 8'h54); tick();
        rd(3'd1, 3'd1, 8'h54); tick();
        idle();
        tick();
        clr = 1;
        tick();
        clr = 0;
        chk("clr_valid", lv_a, 0);
        chk("clr_ovf", ovf_a, 0);
        chk("clr_cnt", cnt_a, 0);
        chk("clr_flag", ff_a, 0);
        tick();
        chk("clr_pipe_flag", ff_a, 0);
        chk("clr_pipe_cnt", cnt_a, 0);

        // Reset while a read is in flight.
        rd(3'd2, 3'd1, 8'h54);
        tick();
        idle();
        tick();
        rstn = 0;
        tick();
        rstn = 1;
        repeat (3) tick();
        chk("rstmid_flag", ff_a, 0);
        chk("rstmid_cnt", cnt_a, 0);
        chk("rstmid_valid", lv_a, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
